// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator call scheduler and the Controller bench:
// floor geometry, scheduler state encodings and dwell-counter sizing.
package elevator_pkg;

  localparam int FLOOR_W      = 5;
  localparam int NUM_FLOORS   = 15;
  localparam int DWELL_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_UP    = 2'b01,
    ST_DOWN  = 2'b10,
    ST_DWELL = 2'b11
  } sched_state_t;

  // Counter holds DWELL_CYCLES-1 down to 0.
  function automatic int dwell_cnt_w(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/floor_search.sv
// Combinational nearest-call search: lowest pending floor above the car and
// highest pending floor below it. The car's own floor is excluded from both.
module floor_search
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic                  above_valid,
  output logic [FLOOR_W-1:0]    above_floor,
  output logic                  below_valid,
  output logic [FLOOR_W-1:0]    below_floor
);

  always_comb begin
    above_valid = 1'b0;
    above_floor = '0;
    below_valid = 1'b0;
    below_floor = '0;
    // Descending scan leaves the lowest qualifying floor in above_floor.
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (FLOOR_W'(i) > current_floor)) begin
        above_valid = 1'b1;
        above_floor = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (FLOOR_W'(i) < current_floor)) begin
        below_valid = 1'b1;
        below_floor = FLOOR_W'(i);
      end
    end
  end

endmodule

// File: rtl/floor_request_scheduler.sv
// Call register plus SCAN scheduler feeding the elevator Controller's target.
//   state | meaning
//   IDLE  | nothing in progress, target tracks the car
//   UP    | heading to the nearest pending floor above the car
//   DOWN  | heading to the nearest pending floor below the car
//   DWELL | doors open at a served floor, target held
module floor_request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W      = elevator_pkg::FLOOR_W,
  parameter int DWELL_CYCLES = elevator_pkg::DWELL_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  arrived,
  output logic [FLOOR_W-1:0]    requested_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  served_valid,
  output logic [FLOOR_W-1:0]    served_floor,
  output logic                  call_reject,
  output logic [1:0]            sched_state
);

  localparam int CNT_W = dwell_cnt_w(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL_CYCLES - 1);

  sched_state_t state_q, state_d;
  sched_state_t dir_q, dir_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [FLOOR_W-1:0]    req_q, req_d;
  logic [FLOOR_W-1:0]    served_floor_q, served_floor_d;
  logic                  served_q, served_d;
  logic                  reject_q, reject_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  above_valid, below_valid;
  logic [FLOOR_W-1:0]    above_floor, below_floor;
  logic [NUM_FLOORS-1:0] call_mask, cur_mask, clear_mask;
  logic                  call_in_range, cur_pend, hit, tie_up;
  logic                  absorb, retarget, retarget_up;

  // Out-of-range floors map to an empty mask, so no index can overrun.
  function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
    floor_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (f == FLOOR_W'(i)) floor_mask[i] = 1'b1;
    end
  endfunction

  floor_search #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_search (
    .pending       (pending_q),
    .current_floor (current_floor),
    .above_valid   (above_valid),
    .above_floor   (above_floor),
    .below_valid   (below_valid),
    .below_floor   (below_floor)
  );

  assign call_in_range = (call_floor < FLOOR_W'(NUM_FLOORS));
  assign call_mask     = call_valid ? floor_mask(call_floor) : '0;
  assign cur_mask      = floor_mask(current_floor);
  assign cur_pend      = |(pending_q & cur_mask);
  assign hit           = arrived && (current_floor == req_q) && cur_pend;
  // Equal distance resolves upward.
  assign tie_up = above_valid &&
                  (!below_valid ||
                   ((above_floor - current_floor) <= (current_floor - below_floor)));

  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    req_d          = req_q;
    cnt_d          = cnt_q;
    served_d       = 1'b0;
    served_floor_d = served_floor_q;
    reject_d       = call_valid && !call_in_range;
    clear_mask     = '0;
    absorb         = 1'b0;
    retarget       = 1'b0;
    retarget_up    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_d = current_floor;
        if (cur_pend) begin
          clear_mask     = cur_mask;
          served_d       = 1'b1;
          served_floor_d = current_floor;
          cnt_d          = CNT_RELOAD;
          dir_d          = ST_IDLE;
          state_d        = ST_DWELL;
        end else begin
          retarget    = 1'b1;
          retarget_up = tie_up;
        end
      end
      ST_UP, ST_DOWN: begin
        if (hit) begin
          clear_mask     = cur_mask;
          served_d       = 1'b1;
          served_floor_d = current_floor;
          cnt_d          = CNT_RELOAD;
          dir_d          = state_q;
          state_d        = ST_DWELL;
        end else if (!(cur_pend && (req_q == current_floor))) begin
          // Car parked on its target but not yet arrived: keep waiting.
          retarget    = 1'b1;
          retarget_up = (state_q == ST_UP) ? above_valid : !below_valid;
        end
      end
      default: begin
        absorb = call_valid && (call_floor == req_q);
        if (absorb) begin
          cnt_d = CNT_RELOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          retarget = 1'b1;
          case (dir_q)
            ST_UP:   retarget_up = above_valid;
            ST_DOWN: retarget_up = !below_valid;
            default: retarget_up = tie_up;
          endcase
        end
      end
    endcase

    if (retarget) begin
      if (above_valid && retarget_up) begin
        state_d = ST_UP;
        req_d   = above_floor;
      end else if (below_valid) begin
        state_d = ST_DOWN;
        req_d   = below_floor;
      end else if (above_valid) begin
        state_d = ST_UP;
        req_d   = above_floor;
      end else begin
        state_d = ST_IDLE;
        req_d   = current_floor;
      end
    end

    // A clear on the same edge as a press for that floor wins.
    pending_d = (pending_q | (absorb ? '0 : call_mask)) & ~clear_mask;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      dir_q          <= ST_IDLE;
      pending_q      <= '0;
      req_q          <= '0;
      served_q       <= 1'b0;
      served_floor_q <= '0;
      reject_q       <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      pending_q      <= pending_d;
      req_q          <= req_d;
      served_q       <= served_d;
      served_floor_q <= served_floor_d;
      reject_q       <= reject_d;
      cnt_q          <= cnt_d;
    end
  end

  assign requested_floor = req_q;
  assign pending         = pending_q;
  assign served_valid    = served_q;
  assign served_floor    = served_floor_q;
  assign call_reject     = reject_q;
  assign sched_state     = state_q;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Bench for floor_request_scheduler: directed scenarios with a served-floor
// scoreboard checked whenever the scheduler pulses served_valid.
module tb_floor_request_scheduler;
  import elevator_pkg::*;

  logic        clk;
  logic        reset;
  logic        call_valid;
  logic [4:0]  call_floor;
  logic [4:0]  current_floor;
  logic        arrived;
  logic [4:0]  requested_floor;
  logic [14:0] pending;
  logic        served_valid;
  logic [4:0]  served_floor;
  logic        call_reject;
  logic [1:0]  sched_state;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int exp_e;

  floor_request_scheduler #(
    .NUM_FLOORS   (15),
    .FLOOR_W      (5),
    .DWELL_CYCLES (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .call_valid      (call_valid),
    .call_floor      (call_floor),
    .current_floor   (current_floor),
    .arrived         (arrived),
    .requested_floor (requested_floor),
    .pending         (pending),
    .served_valid    (served_valid),
    .served_floor    (served_floor),
    .call_reject     (call_reject),
    .sched_state     (sched_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic call(input int f);
    call_valid = 1'b1;
    call_floor = 5'(f);
    tick();
    call_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  task automatic ride(input int from, input int to, input logic [1:0] moving);
    int step;
    step = (to > from) ? 1 : -1;
    arrived = 1'b1;
    for (int f = from + step; f != to; f += step) begin
      current_floor = 5'(f);
      tick();
      chk("ride_state", 32'(sched_state), 32'(moving));
    end
    current_floor = 5'(to);
    tick();
    chk("arrive_state", 32'(sched_state), 32'(ST_DWELL));
  endtask

  task automatic dwell_out(input int served, input logic [1:0] nxt, input int nreq);
    for (int i = 0; i < 4; i++) begin
      chk("dwell_state", 32'(sched_state), 32'(ST_DWELL));
      chk("dwell_req", 32'(requested_floor), 32'(served));
      if (i < 3) tick();
    end
    tick();
    chk("post_dwell_state", 32'(sched_state), 32'(nxt));
    chk("post_dwell_req", 32'(requested_floor), 32'(nreq));
  endtask

  // Served-floor scoreboard; a pulse longer than one cycle pops twice.
  initial begin
    forever begin
      @(negedge clk);
      if (served_valid) begin
        if (exp_q.size() == 0) begin
          chk("served_unexpected", 32'(served_floor), 32'hFFFF);
        end else begin
          exp_e = exp_q.pop_front();
          chk("served_floor", 32'(served_floor), 32'(exp_e));
        end
      end
    end
  end

  initial begin
    reset         = 1'b0;
    call_valid    = 1'b0;
    call_floor    = '0;
    current_floor = '0;
    arrived       = 1'b0;
    #2;
    chk("rst_pending", 32'(pending), 0);
    chk("rst_state", 32'(sched_state), 32'(ST_IDLE));
    chk("rst_req", 32'(requested_floor), 0);
    chk("rst_served", 32'(served_valid), 0);
    chk("rst_reject", 32'(call_reject), 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("idle_state", 32'(sched_state), 32'(ST_IDLE));

    // Single call up from floor 0 to 5.
    call(5);
    chk("c5_pending", 32'(pending), 32'h0020);
    chk("c5_state_k", 32'(sched_state), 32'(ST_IDLE));
    tick();
    chk("c5_state_k1", 32'(sched_state), 32'(ST_UP));
    chk("c5_req_k1", 32'(requested_floor), 5);
    exp_q.push_back(5);
    ride(0, 5, ST_UP);
    chk("c5_cleared", 32'(pending), 0);
    dwell_out(5, ST_IDLE, 5);

    // Call at the car's own floor, repeat absorbed during dwell.
    current_floor = 5'd4;
    arrived = 1'b0;
    tick();
    chk("idle_track", 32'(requested_floor), 4);
    call(4);
    chk("c4_pending", 32'(pending), 32'h0010);
    exp_q.push_back(4);
    tick();
    chk("c4_state", 32'(sched_state), 32'(ST_DWELL));
    chk("c4_cleared", 32'(pending), 0);
    tick();
    call(4);
    chk("c4_absorbed", 32'(pending), 0);
    dwell_out(4, ST_IDLE, 4);

    // Out-of-range call rejected.
    call_valid = 1'b1;
    call_floor = 5'd15;
    tick();
    call_valid = 1'b0;
    chk("rej_pulse", 32'(call_reject), 1);
    chk("rej_pending", 32'(pending), 0);
    tick();
    chk("rej_single", 32'(call_reject), 0);

    // Asynchronous reset while heading up.
    call(8);
    call(9);
    chk("ar_state", 32'(sched_state), 32'(ST_UP));
    chk("ar_req", 32'(requested_floor), 8);
    chk("ar_pending", 32'(pending), 32'h0300);
    reset = 1'b0;
    #2;
    chk("ar_pending0", 32'(pending), 0);
    chk("ar_state0", 32'(sched_state), 32'(ST_IDLE));
    chk("ar_req0", 32'(requested_floor), 0);
    chk("ar_served_floor0", 32'(served_floor), 0);
    chk("ar_served0", 32'(served_valid), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    chk("ar_after_state", 32'(sched_state), 32'(ST_IDLE));

    // Top floor accepted.
    call(14);
    chk("c14_pending", 32'(pending), 32'h4000);
    chk("c14_reject", 32'(call_reject), 0);
    reset_pulse();

    // SCAN ordering: heading up to 9 from 5, calls 7 and 3 arrive.
    current_floor = 5'd5;
    arrived = 1'b0;
    tick();
    call(9);
    tick();
    chk("scan_state", 32'(sched_state), 32'(ST_UP));
    chk("scan_req9", 32'(requested_floor), 9);
    call(7);
    chk("scan_pend79", 32'(pending), 32'h0280);
    call(3);
    chk("scan_preempt", 32'(requested_floor), 7);
    chk("scan_pend379", 32'(pending), 32'h0288);
    exp_q.push_back(7);
    exp_q.push_back(9);
    exp_q.push_back(3);
    ride(5, 7, ST_UP);
    chk("scan_pend39", 32'(pending), 32'h0208);
    dwell_out(7, ST_UP, 9);
    ride(7, 9, ST_UP);
    dwell_out(9, ST_DOWN, 3);
    ride(9, 3, ST_DOWN);
    dwell_out(3, ST_IDLE, 3);

    // Equidistant calls 4 and 8 with the car at 6 and no direction: up wins.
    current_floor = 5'd6;
    arrived = 1'b0;
    tick();
    call(6);
    chk("tie_pend6", 32'(pending), 32'h0040);
    exp_q.push_back(6);
    tick();
    chk("tie_dwell", 32'(sched_state), 32'(ST_DWELL));
    call(4);
    call(8);
    chk("tie_pending", 32'(pending), 32'h0110);
    tick();
    tick();
    chk("tie_state", 32'(sched_state), 32'(ST_UP));
    chk("tie_req", 32'(requested_floor), 8);

    // Single call below an idle car.
    reset_pulse();
    call(2);
    tick();
    chk("down_state", 32'(sched_state), 32'(ST_DOWN));
    chk("down_req", 32'(requested_floor), 2);

    tick();
    chk("sb_left", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
